seq_capture_fifo: RTL and testbench

Downstream consumer for the 8-bit sequence generator's output stream (`top_level` `__out0`). On every cycle where the generator's advance bit is high, it captures the generator output into a small FIFO. It then presents the samples to the next stage over a valid/ready handshake. A compile-time option adds a recurrence checker that flags any captured sample that is not the 8-bit sum of the two before it.

---
 rtl/seq_capture_pkg.sv | 13 +
 rtl/seq_recur_check.sv | 65 ++++++
 rtl/seq_capture_fifo.sv | 88 ++++++++
 tb/tb_seq_capture_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_capture_pkg.sv
// Shared types and defaults for the sequence-capture FIFO and its recurrence checker.
package seq_capture_pkg;
   localparam int SEQ_DEPTH_DFLT = 4;
   localparam int SEQ_WIDTH_DFLT = 8;

   typedef logic [SEQ_WIDTH_DFLT-1:0] sample_t;

   typedef enum logic [1:0] {
      CK_IDLE,
      CK_ONE,
      CK_RUN
   } ck_state_t;
endpackage

// File: rtl/seq_recur_check.sv
// Recurrence checker: flags (sticky) any captured sample that is not the WIDTH-bit
// sum of the two samples captured before it.
module seq_recur_check
   import seq_capture_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic [WIDTH-1:0] samp,
   output logic             mismatch
);

   ck_state_t        state_q, state_d;
   logic [WIDTH-1:0] p1_q, p1_d;
   logic [WIDTH-1:0] p2_q, p2_d;
   logic             mismatch_q, mismatch_d;
   logic [WIDTH-1:0] sum;

   always_comb begin
      state_d    = state_q;
      p1_d       = p1_q;
      p2_d       = p2_q;
      mismatch_d = mismatch_q;
      // Carry out is dropped on purpose: wrap-around is a legal sequence step.
      sum        = p1_q + p2_q;
      if (adv) begin
         case (state_q)
            CK_IDLE: begin
               p1_d    = samp;
               state_d = CK_ONE;
            end
            CK_ONE: begin
               p2_d    = p1_q;
               p1_d    = samp;
               state_d = CK_RUN;
            end
            default: begin
               if (samp != sum) mismatch_d = 1'b1;
               p2_d    = p1_q;
               p1_d    = samp;
               state_d = CK_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CK_IDLE;
         p1_q       <= '0;
         p2_q       <= '0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch = mismatch_q;

endmodule

// File: rtl/seq_capture_fifo.sv
// Capture FIFO for the sequence generator stream with valid/ready output.
// Define SEQ_CAPTURE_CHECK_EN to build the recurrence checker driving `mismatch`.
module seq_capture_fifo
   import seq_capture_pkg::*;
#(
   parameter int DEPTH = SEQ_DEPTH_DFLT,
   parameter int WIDTH = SEQ_WIDTH_DFLT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     adv,
   input  logic [WIDTH-1:0]         samp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     mismatch
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             empty, full, push, pop;

   always_comb begin
      empty      = (count_q == '0);
      full       = (count_q == CW'(DEPTH));
      pop        = !empty && out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push       = adv && (!full || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (adv & full & ~pop);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= samp;
   end

   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;

`ifdef SEQ_CAPTURE_CHECK_EN
   seq_recur_check #(
      .WIDTH (WIDTH)
   ) u_check (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .samp     (samp),
      .mismatch (mismatch)
   );
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_seq_capture_fifo.sv
// Randomized and directed bench for seq_capture_fifo against a queue-based reference model.
module tb_seq_capture_fifo;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             adv;
   logic [WIDTH-1:0] samp;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [$clog2(DEPTH):0] count;
   logic             overflow;
   logic             mismatch;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] hist[$];
   logic             m_ovf;

   seq_capture_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .samp      (samp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_mismatch();
      logic bad;
      bad = 1'b0;
`ifdef SEQ_CAPTURE_CHECK_EN
      for (int i = 2; i < hist.size(); i++) begin
         if (hist[i] != WIDTH'((int'(hist[i-1]) + int'(hist[i-2])) % 256)) bad = 1'b1;
      end
`endif
      return bad;
   endfunction

   task automatic check_outputs(input string tag);
      logic [WIDTH-1:0] head;
      head = (q.size() != 0) ? q[0] : '0;
      chk({tag, ".valid"},    32'(out_valid), 32'(q.size() != 0));
      chk({tag, ".data"},     32'(out_data),  32'(head));
      chk({tag, ".count"},    32'(count),     32'(q.size()));
      chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
      chk({tag, ".mismatch"}, 32'(mismatch),  32'(exp_mismatch()));
   endtask

   task automatic model_edge(input logic a, input logic [WIDTH-1:0] s, input logic r);
      logic p, f;
      p = (q.size() != 0) && r;
      f = (q.size() == DEPTH);
      if (p) void'(q.pop_front());
      if (a) begin
         hist.push_back(s);
         if (f && !p) m_ovf = 1'b1;
         else q.push_back(s);
      end
   endtask

   // Entered and left at a falling edge.
   task automatic step(input string tag, input logic a, input logic [WIDTH-1:0] s, input logic r);
      adv = a; samp = s; out_ready = r;
      @(posedge clk);
      model_edge(a, s, r);
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic reset_mid(input string tag);
      rst = 1'b1; adv = 1'b0; out_ready = 1'b0;
      #1;
      q.delete(); hist.delete(); m_ovf = 1'b0;
      check_outputs(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] g1, g2, s;
      logic             a, r;
      int               ncap;

      rst = 1'b1; adv = 1'b0; samp = '0; out_ready = 1'b0; m_ovf = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst = 1'b0;

      step("ord", 1'b1, 8'h00, 1'b0);
      step("ord", 1'b1, 8'h01, 1'b0);
      step("ord", 1'b1, 8'h01, 1'b0);
      chk("ord_count3", 32'(count), 32'd3);
      for (int i = 0; i < 4; i++) step("ord_drain", 1'b0, 8'h00, 1'b1);
      chk("ord_empty", 32'(out_valid), 32'd0);

      reset_mid("rst_pre");
      for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, WIDTH'(8'h30 + i), 1'b0);
      reset_mid("rst_mid");
      step("rst_next", 1'b1, 8'hA5, 1'b0);
      chk("rst_head", 32'(out_data), 32'h A5);

      reset_mid("ovf_rst");
      for (int i = 0; i < 5; i++) step("ovf_push", 1'b1, WIDTH'(8'h10 + i), 1'b0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      for (int i = 0; i < 5; i++) step("ovf_drain", 1'b0, 8'h00, 1'b1);

      reset_mid("fpp_rst");
      for (int i = 0; i < 4; i++) step("fpp_fill", 1'b1, WIDTH'(8'h20 + i), 1'b0);
      step("fpp_both", 1'b1, 8'h55, 1'b1);
      chk("fpp_ovf", 32'(overflow), 32'd0);
      chk("fpp_count", 32'(count), 32'd4);
      for (int i = 0; i < 3; i++) step("fpp_drain", 1'b0, 8'h00, 1'b1);
      chk("fpp_last", 32'(out_data), 32'h55);
      step("fpp_drain", 1'b0, 8'h00, 1'b1);

      reset_mid("ck_rst");
      step("ck", 1'b1, 8'd0, 1'b1);
      step("ck", 1'b1, 8'd1, 1'b1);
      step("ck", 1'b1, 8'd1, 1'b1);
      step("ck", 1'b1, 8'd2, 1'b1);
      step("ck", 1'b1, 8'd3, 1'b1);
      step("ck", 1'b1, 8'd5, 1'b1);
      step("ck", 1'b1, 8'd8, 1'b1);
      chk("ck_clean", 32'(mismatch), 32'd0);
      step("ck_bad", 1'b1, 8'h0C, 1'b1);
`ifdef SEQ_CAPTURE_CHECK_EN
      chk("ck_flag", 32'(mismatch), 32'd1);
`else
      chk("ck_flag", 32'(mismatch), 32'd0);
`endif
      step("ck_hold", 1'b0, 8'h00, 1'b1);
      step("ck_hold", 1'b1, 8'd20, 1'b1);

      reset_mid("wrap_rst");
      step("wrap", 1'b1, 8'hC8, 1'b1);
      step("wrap", 1'b1, 8'h64, 1'b1);
      step("wrap", 1'b1, 8'h2C, 1'b1);
      chk("wrap_clean", 32'(mismatch), 32'd0);

      for (int rnd = 0; rnd < 8; rnd++) begin
         reset_mid("rand_rst");
         g1 = WIDTH'($urandom); g2 = WIDTH'($urandom);
         ncap = 0;
         for (int c = 0; c < 60; c++) begin
            a = ($urandom % 4) != 0;
            r = ($urandom % 3) != 0;
            s = WIDTH'($urandom);
            if (a) begin
               if (ncap == 0)      s = g2;
               else if (ncap == 1) s = g1;
               else begin
                  s = g1 + g2;
                  if ((rnd % 2) == 1 && ($urandom % 20) == 0) s = s ^ 8'h01;
               end
               if (ncap >= 1) g2 = g1;
               g1 = s;
               ncap++;
            end
            step("rand", a, s, r);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
